// File: rtl/regfile_scb.sv
// Register file with 2R/1W ports, write-through bypass and a busy scoreboard.
// Issue logic locks a destination; write-back releases it. stall flags RAW hazards.
module regfile_scb #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_W-1:0]       ra,
   input  logic [ADDR_W-1:0]       rb,
   input  logic                    re,
   output logic [DATA_W-1:0]       a,
   output logic [DATA_W-1:0]       b,
   input  logic                    we,
   input  logic [ADDR_W-1:0]       wa,
   input  logic [DATA_W-1:0]       wd,
   input  logic                    lock_en,
   input  logic [ADDR_W-1:0]       lock_addr,
   output logic                    stall,
   output logic [(2**ADDR_W)-1:0]  busy
);

   localparam int NREG = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [NREG];
   logic [DATA_W-1:0] mem_d [NREG];
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [NREG-1:0]   busy_q, busy_d;

   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
      return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
   endfunction

   // Priority: hardwired zero, then same-cycle write-back, then stored value.
   function automatic logic [DATA_W-1:0] read_src(
      input logic [ADDR_W-1:0] addr,
      input logic              wr_en,
      input logic [ADDR_W-1:0] wr_addr,
      input logic [DATA_W-1:0] wr_data,
      input logic [DATA_W-1:0] stored
   );
      logic [DATA_W-1:0] val;
      if (is_zero_reg(addr)) begin
         val = {DATA_W{1'b0}};
      end else if (wr_en && (wr_addr == addr)) begin
         val = wr_data;
      end else begin
         val = stored;
      end
      return val;
   endfunction

   // A register whose producer writes back this cycle is no longer a hazard.
   function automatic logic pending(
      input logic [ADDR_W-1:0] addr,
      input logic [NREG-1:0]   busy_vec,
      input logic              wr_en,
      input logic [ADDR_W-1:0] wr_addr
   );
      return busy_vec[addr] && !(wr_en && (wr_addr == addr));
   endfunction

   // Read port next-state: capture on re, otherwise hold.
   always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (re) begin
         a_d = read_src(ra, we, wa, wd, mem_q[ra]);
         b_d = read_src(rb, we, wa, wd, mem_q[rb]);
      end else begin
         a_d = a_q;
         b_d = b_q;
      end
   end

   // Storage next-state: single write port, register 0 optionally immutable.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         mem_d[i] = mem_q[i];
         if (we && (wa == ADDR_W'(i)) && !is_zero_reg(wa)) begin
            mem_d[i] = wd;
         end else begin
            mem_d[i] = mem_q[i];
         end
      end
   end

   // Scoreboard next-state: a lock beats a release on the same register.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NREG; i++) begin
         if (lock_en && (lock_addr == ADDR_W'(i)) && !is_zero_reg(lock_addr)) begin
            busy_d[i] = 1'b1;
         end else if (we && (wa == ADDR_W'(i))) begin
            busy_d[i] = 1'b0;
         end else begin
            busy_d[i] = busy_q[i];
         end
      end
   end

   // State registers; reset clears storage, read data and scoreboard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= {DATA_W{1'b0}};
         end
         a_q    <= {DATA_W{1'b0}};
         b_q    <= {DATA_W{1'b0}};
         busy_q <= {NREG{1'b0}};
      end else begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= mem_d[i];
         end
         a_q    <= a_d;
         b_q    <= b_d;
         busy_q <= busy_d;
      end
   end

   assign stall = re && (pending(ra, busy_q, we, wa) || pending(rb, busy_q, we, wa));
   assign a     = a_q;
   assign b     = b_q;
   assign busy  = busy_q;

endmodule
